// File: rtl/seq_gen.sv
// Serial pattern generator: shifts a latched pattern out MSB-first, repeating it
// rep+1 times with an optional idle gap between passes. All outputs are registered.
module seq_gen #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] rep,
  input  logic [CNT_W-1:0] gap,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state_o
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   pat_q, pat_d;
  logic [IDX_W-1:0]   len_m1_q, len_m1_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   rep_q, rep_d;
  logic [CNT_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               x_q, x_d;
  logic               xv_q, xv_d;
  logic               fs_q, fs_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [LEN_W-1:0]   len_clamped;
  logic [IDX_W-1:0]   load_idx;
  logic [IDX_W-1:0]   idx_dec;

  // Over-long lengths are clamped so the index never leaves the pattern register.
  assign len_clamped = (len > WIDTH_L) ? WIDTH_L : len;
  assign load_idx    = IDX_W'(len_clamped - LEN_W'(1));
  assign idx_dec     = idx_q - IDX_W'(1);

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_m1_d  = len_m1_q;
    idx_d     = idx_q;
    rep_d     = rep_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    x_d       = 1'b0;
    xv_d      = 1'b0;
    fs_d      = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && (len != '0)) begin
          state_d  = S_SHIFT;
          pat_d    = pattern;
          len_m1_d = load_idx;
          idx_d    = load_idx;
          rep_d    = rep;
          gap_d    = gap;
          x_d      = pattern[load_idx];
          xv_d     = 1'b1;
          fs_d     = 1'b1;
          busy_d   = 1'b1;
        end
      end

      S_SHIFT: begin
        if (idx_q != '0) begin
          idx_d  = idx_dec;
          x_d    = pat_q[idx_dec];
          xv_d   = 1'b1;
          busy_d = 1'b1;
        end else if (rep_q != '0) begin
          rep_d  = rep_q - CNT_W'(1);
          busy_d = 1'b1;
          if (gap_q == '0) begin
            idx_d = len_m1_q;
            x_d   = pat_q[len_m1_q];
            xv_d  = 1'b1;
            fs_d  = 1'b1;
          end else begin
            // The entry edge already produces the first gap cycle.
            state_d   = S_GAP;
            gap_cnt_d = gap_q - CNT_W'(1);
          end
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      S_GAP: begin
        busy_d = 1'b1;
        if (gap_cnt_q == '0) begin
          state_d = S_SHIFT;
          idx_d   = len_m1_q;
          x_d     = pat_q[len_m1_q];
          xv_d    = 1'b1;
          fs_d    = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      len_m1_q  <= '0;
      idx_q     <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      x_q       <= 1'b0;
      xv_q      <= 1'b0;
      fs_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_m1_q  <= len_m1_d;
      idx_q     <= idx_d;
      rep_q     <= rep_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      x_q       <= x_d;
      xv_q      <= xv_d;
      fs_q      <= fs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign x           = x_q;
  assign x_valid     = xv_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: each step advances one clock and checks the packed
// output vector {x, x_valid, frame_start, busy, done} against a hand-computed value.
module tb_seq_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] rep;
  logic [3:0] gap;
  logic       x;
  logic       x_valid;
  logic       frame_start;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;

  logic [2:0] hist = 3'b000;
  int         det  = 0;

  seq_gen #(.WIDTH(8), .LEN_W(4), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pattern     (pattern),
    .len         (len),
    .rep         (rep),
    .gap         (gap),
    .x           (x),
    .x_valid     (x_valid),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference 110 detector on the valid serial stream
  always @(negedge clk) begin
    if (x_valid) begin
      hist = {hist[1:0], x};
      if (hist == 3'b110) det++;
    end
  end

  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {x, x_valid, frame_start, busy, done};
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [4:0] exp);
    @(posedge clk);
    #1;
    chk(tag, exp);
  endtask

  task automatic set_in(input logic s, input logic [7:0] p, input logic [3:0] l,
                        input logic [3:0] r, input logic [3:0] g);
    start   = s;
    pattern = p;
    len     = l;
    rep     = r;
    gap     = g;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] p;
    logic       b;

    // reset
    rst = 1'b0;
    set_in(1'b0, 8'h00, 4'd0, 4'd0, 4'd0);
    #1;
    chk("reset_async", 5'b00000);
    chk_int("reset_state", int'(dbg_state), 0);
    @(posedge clk); #1;
    chk("reset_hold", 5'b00000);
    rst = 1'b1;
    step("idle", 5'b00000);

    // test 1: 110, len=3
    set_in(1'b1, 8'b0000_0110, 4'd3, 4'd0, 4'd0);
    step("t1_c1", 5'b11110);
    start = 1'b0;
    step("t1_c2", 5'b11010);
    step("t1_c3", 5'b01010);
    step("t1_done", 5'b00001);
    step("t1_after", 5'b00000);
    chk_int("t1_det110", det, 1);

    // test 2: len=8, rep=2, gap=0; input changes and mid-run start ignored
    p = 8'b1010_0011;
    set_in(1'b1, p, 4'd8, 4'd2, 4'd0);
    for (int k = 0; k < 24; k++) begin
      b = p[7 - (k % 8)];
      step($sformatf("t2_c%0d", k + 1), {b, 1'b1, (k % 8) == 0, 1'b1, 1'b0});
      if (k == 0) set_in(1'b0, 8'h00, 4'd8, 4'd2, 4'd0);
      if (k == 9) set_in(1'b1, 8'hFF, 4'd3, 4'd0, 4'd0);
      if (k == 10) start = 1'b0;
    end
    step("t2_done", 5'b00001);
    step("t2_after", 5'b00000);

    // test 3: 101, rep=1, gap=2
    set_in(1'b1, 8'b0000_0101, 4'd3, 4'd1, 4'd2);
    step("t3_c1", 5'b11110);
    start = 1'b0;
    step("t3_c2", 5'b01010);
    step("t3_c3", 5'b11010);
    step("t3_gap1", 5'b00010);
    step("t3_gap2", 5'b00010);
    step("t3_c6", 5'b11110);
    step("t3_c7", 5'b01010);
    step("t3_c8", 5'b11010);
    step("t3_done", 5'b00001);
    step("t3_after", 5'b00000);

    // test 4a: len=0 ignored
    set_in(1'b1, 8'hFF, 4'd0, 4'd3, 4'd1);
    step("t4a_c1", 5'b00000);
    step("t4a_c2", 5'b00000);
    start = 1'b0;
    step("t4a_c3", 5'b00000);

    // test 4b: len=12 clamps to 8
    p = 8'b1100_1010;
    set_in(1'b1, p, 4'd12, 4'd0, 4'd0);
    for (int k = 0; k < 8; k++) begin
      b = p[7 - k];
      step($sformatf("t4b_c%0d", k + 1), {b, 1'b1, k == 0, 1'b1, 1'b0});
      start = 1'b0;
    end
    step("t4b_done", 5'b00001);

    // test 4c: len=1, rep=2 -> frame_start every bit
    set_in(1'b1, 8'b0000_0001, 4'd1, 4'd2, 4'd0);
    step("t4c_c1", 5'b11110);
    start = 1'b0;
    step("t4c_c2", 5'b11110);
    step("t4c_c3", 5'b11110);
    step("t4c_done", 5'b00001);

    // test 5: reset at bit 4 of an 8-bit pass
    set_in(1'b1, 8'b1011_0110, 4'd8, 4'd0, 4'd0);
    step("t5_c1", 5'b11110);
    start = 1'b0;
    step("t5_c2", 5'b01010);
    step("t5_c3", 5'b11010);
    step("t5_c4", 5'b11010);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_rst_now", 5'b00000);
    @(posedge clk); #1;
    chk("t5_rst_hold", 5'b00000);
    rst = 1'b1;
    step("t5_nodone1", 5'b00000);
    step("t5_nodone2", 5'b00000);
    p = 8'b1011_0110;
    set_in(1'b1, p, 4'd8, 4'd0, 4'd0);
    for (int k = 0; k < 8; k++) begin
      b = p[7 - k];
      step($sformatf("t5r_c%0d", k + 1), {b, 1'b1, k == 0, 1'b1, 1'b0});
      start = 1'b0;
    end
    step("t5r_done", 5'b00001);

    // test 6: start held high, len=2
    set_in(1'b1, 8'b0000_0010, 4'd2, 4'd0, 4'd0);
    step("t6_c1", 5'b11110);
    step("t6_c2", 5'b01010);
    step("t6_done1", 5'b00001);
    step("t6_c4", 5'b11110);
    step("t6_c5", 5'b01010);
    step("t6_done2", 5'b00001);
    start = 1'b0;
    step("t6_idle", 5'b00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
